timer_prog_multimode: RTL and testbench



---
 rtl/timer_prog_multimode.sv | 107 ++++++++++
 tb/tb_timer_prog_multimode.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_prog_multimode.sv
// timer_prog_multimode: programmable terminal-count timer with a prescaler,
// one-shot and periodic modes, start/stop control, busy status and a visible count.
// Optional build macro TIMER_IRQ_STICKY_EN adds irq_clr/irq, a sticky event flag
// that is set by every saturation pulse.
module timer_prog_multimode #(
    parameter int unsigned N = 16,
    parameter int unsigned P = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         start,
    input  logic         stop,
    input  logic         periodic,
    input  logic [N-1:0] saturation_value,
    input  logic [P-1:0] prescale,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         saturation
`ifdef TIMER_IRQ_STICKY_EN
    ,
    input  logic         irq_clr,
    output logic         irq
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state;
    logic [P-1:0] pcnt;
    logic [N-1:0] s_q;
    logic [P-1:0] d_q;
    logic         mode_q;

    logic tick_c;
    logic wrap_c;

    // Tick when the prescaler reaches its terminal value. A wrap is a tick
    // at the terminal count that no stop or start request overrides.
    assign tick_c = (state == RUN) && enable && (pcnt == d_q);
    assign wrap_c = tick_c && (count == s_q) && !stop && !start;

    // Control state, prescaler, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            pcnt       <= '0;
            busy       <= 1'b0;
            saturation <= 1'b0;
            s_q        <= '0;
            d_q        <= '0;
            mode_q     <= 1'b0;
        end else begin
            saturation <= 1'b0;
            if (stop) begin
                state <= IDLE;
                count <= '0;
                pcnt  <= '0;
                busy  <= 1'b0;
            end else if (start) begin
                state  <= RUN;
                count  <= '0;
                pcnt   <= '0;
                busy   <= 1'b1;
                s_q    <= saturation_value;
                d_q    <= prescale;
                mode_q <= periodic;
            end else if (state == RUN && enable) begin
                if (tick_c) begin
                    pcnt <= '0;
                    if (wrap_c) begin
                        count      <= '0;
                        saturation <= 1'b1;
                        if (mode_q) begin
                            s_q <= saturation_value;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        count <= count + N'(1);
                    end
                end else begin
                    pcnt <= pcnt + P'(1);
                end
            end
        end
    end

`ifdef TIMER_IRQ_STICKY_EN
    // Sticky event flag: set wins over a coincident clear so no event is lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else if (wrap_c) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_timer_prog_multimode.sv
// Directed bench for timer_prog_multimode: expected values are queued when a
// step is driven and popped when the DUT output is sampled after the edge.
module tb_timer_prog_multimode;

    localparam int unsigned N = 16;
    localparam int unsigned P = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         start;
    logic         stop;
    logic         periodic;
    logic [N-1:0] saturation_value;
    logic [P-1:0] prescale;
    logic [N-1:0] count;
    logic         busy;
    logic         saturation;
`ifdef TIMER_IRQ_STICKY_EN
    logic         irq_clr;
    logic         irq;
`endif

    timer_prog_multimode #(.N(N), .P(P)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .start            (start),
        .stop             (stop),
        .periodic         (periodic),
        .saturation_value (saturation_value),
        .prescale         (prescale),
        .count            (count),
        .busy             (busy),
        .saturation       (saturation)
`ifdef TIMER_IRQ_STICKY_EN
        ,
        .irq_clr          (irq_clr),
        .irq              (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one edge and sample away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp3(input string tag, input int c, input logic b, input logic s);
        push({tag, "_count"}, 32'(c));
        push({tag, "_busy"}, 32'(b));
        push({tag, "_sat"}, 32'(s));
    endtask

    task automatic chk3();
        chk(32'(count));
        chk(32'(busy));
        chk(32'(saturation));
    endtask

    // Edges until the next saturation pulse; -1 if none within the bound.
    task automatic wait_pulse(output int n);
        n = -1;
        for (int i = 1; i <= 2000; i++) begin
            cyc();
            if (saturation === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_start(input logic [N-1:0] s, input logic [P-1:0] d, input logic per);
        saturation_value = s;
        prescale         = d;
        periodic         = per;
        start            = 1'b1;
        cyc();
        start            = 1'b0;
    endtask

    int n;
    int pulses;

    initial begin
        reset_n          = 1'b0;
        enable           = 1'b1;
        start            = 1'b0;
        stop             = 1'b0;
        periodic         = 1'b0;
        saturation_value = '0;
        prescale         = '0;
`ifdef TIMER_IRQ_STICKY_EN
        irq_clr          = 1'b0;
`endif

        // Reset state
        exp3("reset", 0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk3();
        reset_n = 1'b1;

        // One-shot S=3 D=0: counts 0..3 then pulse with busy dropping
        exp3("os_start", 0, 1'b1, 1'b0);
        do_start(16'd3, 8'd0, 1'b0);
        chk3();
        for (int k = 1; k <= 3; k++) begin
            exp3($sformatf("os_c%0d", k), k, 1'b1, 1'b0);
            cyc();
            chk3();
        end
        exp3("os_pulse", 0, 1'b0, 1'b1);
        cyc();
        chk3();
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (saturation !== 1'b0 || busy !== 1'b0) pulses++;
        end
        push("os_no_more", 0);
        chk(32'(pulses));

        // Periodic S=255 D=0: pulse every 256 cycles, busy held
        do_start(16'd255, 8'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            push($sformatf("p255_period%0d", k), 256);
            wait_pulse(n);
            chk(32'(n));
            push($sformatf("p255_busy%0d", k), 1);
            chk(32'(busy));
        end
        push("p255_pulse_width", 0);
        cyc();
        chk(32'(saturation));

        // Periodic S=9 D=4: 50-cycle period; mid-period change to 4 then 25
        do_start(16'd9, 8'd4, 1'b1);
        push("p9_first", 50);
        wait_pulse(n);
        chk(32'(n));
        for (int k = 0; k < 10; k++) cyc();
        saturation_value = 16'd4;
        prescale         = 8'd0;
        push("p9_current", 40);
        wait_pulse(n);
        chk(32'(n));
        push("p4_next", 25);
        wait_pulse(n);
        chk(32'(n));
        push("p4_again", 25);
        wait_pulse(n);
        chk(32'(n));
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // Enable gating S=5 D=0: hold at 2 for 7 cycles, pulse delayed by 7
        do_start(16'd5, 8'd0, 1'b0);
        cyc();
        exp3("gate_at2", 2, 1'b1, 1'b0);
        cyc();
        chk3();
        enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            exp3($sformatf("gate_hold%0d", k), 2, 1'b1, 1'b0);
            cyc();
            chk3();
        end
        enable = 1'b1;
        push("gate_remaining", 4);
        wait_pulse(n);
        chk(32'(n));
        push("gate_busy_after", 0);
        chk(32'(busy));

        // Prescaler boundary D=255 with S=2: 768 cycles
        do_start(16'd2, 8'd255, 1'b0);
        push("d255_period", 768);
        wait_pulse(n);
        chk(32'(n));

        // S=0 D=0 periodic: pulse on every cycle
        do_start(16'd0, 8'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            exp3($sformatf("s0_cyc%0d", k), 0, 1'b1, 1'b1);
            cyc();
            chk3();
        end
        stop = 1'b1;
        exp3("s0_stop", 0, 1'b0, 1'b0);
        cyc();
        chk3();
        stop = 1'b0;

        // Stop at count 3: IDLE, count 0, no pulse afterwards
        do_start(16'd10, 8'd0, 1'b0);
        cyc();
        cyc();
        exp3("stop_at3", 3, 1'b1, 1'b0);
        cyc();
        chk3();
        stop = 1'b1;
        exp3("stop_idle", 0, 1'b0, 1'b0);
        cyc();
        chk3();
        stop = 1'b0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            cyc();
            if (saturation !== 1'b0) pulses++;
        end
        push("stop_no_pulse", 0);
        chk(32'(pulses));

        // Start and stop together: stop wins
        start = 1'b1;
        stop  = 1'b1;
        exp3("start_stop", 0, 1'b0, 1'b0);
        cyc();
        chk3();
        start = 1'b0;
        stop  = 1'b0;
        exp3("start_stop_after", 0, 1'b0, 1'b0);
        cyc();
        chk3();

        // Restart while running at count 4
        do_start(16'd10, 8'd0, 1'b0);
        for (int k = 0; k < 4; k++) cyc();
        push("restart_at4", 4);
        chk(32'(count));
        exp3("restart", 0, 1'b1, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk3();
        exp3("restart_next", 1, 1'b1, 1'b0);
        cyc();
        chk3();

        // Reset mid-run clears outputs on that edge and stays idle
        cyc();
        reset_n = 1'b0;
        exp3("rst_mid", 0, 1'b0, 1'b0);
        cyc();
        chk3();
        reset_n = 1'b1;
        exp3("rst_after", 0, 1'b0, 1'b0);
        cyc();
        chk3();

`ifdef TIMER_IRQ_STICKY_EN
        // Sticky irq with S=0 D=0 periodic
        push("irq_reset", 0);
        chk(32'(irq));
        do_start(16'd0, 8'd0, 1'b1);
        push("irq_before_pulse", 0);
        chk(32'(irq));
        push("irq_first", 1);
        cyc();
        chk(32'(irq));
        irq_clr = 1'b1;
        push("irq_clr_on_pulse", 1);
        cyc();
        chk(32'(irq));
        irq_clr = 1'b0;
        stop = 1'b1;
        push("irq_hold_stop", 1);
        cyc();
        chk(32'(irq));
        stop = 1'b0;
        push("irq_hold_idle", 1);
        cyc();
        chk(32'(irq));
        irq_clr = 1'b1;
        push("irq_cleared", 0);
        cyc();
        chk(32'(irq));
        irq_clr = 1'b0;
`endif

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
